pin_entry_collector: RTL and testbench
======================================

# pin_entry_collector

Assembles debounced keypad presses into a `pinPac_t` packet: the producing end of the PIN packet interface read by the master-PIN updater and the PIN comparator. It collects up to four decimal digits, confirms on `*`, clears on `#` or on inactivity timeout, and emits the packet with a one-cycle `status` strobe. It sits between the keypad scanner/debouncer and every PIN consumer.

## Interface
- `TIMEOUT_CYCLES`, default 32'd125_000_000: idle cycles in COLLECT before the partial entry is discarded; 0 disables the timeout.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key_valid` in 1: single-cycle strobe, one per debounced key press.
- `key_code` in 4: 0–9 digit, 4'hA `*` (confirm), 4'hB `#` (clear), 4'hC–4'hF ignored.
- `pin_out` out `pinPac_t`: `{status, digit1..digit4}`; digit1 is the oldest retained digit.
- `digit_count` out 3: digits held, 0–4.
- `busy` out 1: high while in COLLECT.
- `timed_out` out 1: one-cycle pulse when the timeout discards an entry.

## Operation
- Reset: all outputs go to 0, every digit field goes to 4'hF, the state goes to IDLE and the timer clears.
- States and transitions:
  - IDLE → COLLECT on a digit key; the first digit goes to digit1.
  - IDLE → CONFIRM on `*`; the packet is emitted with all fields 4'hF.
  - COLLECT → CONFIRM on `*`.
  - COLLECT → IDLE on `#` or on timeout.
  - CONFIRM → IDLE always, after exactly one cycle.
- Digit entry with count < 4: the digit is written to field `count+1`, and the count increments.
- Digit entry with count = 4: the window shifts (digit1←digit2, digit2←digit3, digit3←digit4, digit4←new), and the count stays 4. The packet always holds the last four digits typed.
- Unfilled fields stay 4'hF. A packet confirmed with fewer than 4 digits is still emitted; consumers reject it via the >9 check.
- `#`: all fields return to 4'hF and the count goes to 0. `#` in IDLE is a no-op.
- Codes 4'hC–4'hF are dropped with no state change and no timer reset.
- Any key in CONFIRM is dropped.
- Timer:
  - Clears on every accepted key.
  - Increments each COLLECT cycle without `key_valid`.
  - Reaching `TIMEOUT_CYCLES` clears the entry, pulses `timed_out` and returns to IDLE.
  - If a key and timer expiry occur in the same cycle, the key wins, the timer clears and no timeout fires.
- Width rule: the counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates; it never wraps.

## Timing
- Digits: a `key_valid` digit sampled at edge N is visible in `pin_out`/`digit_count` after edge N.
- Confirm: `*` sampled at edge N gives `pin_out.status`=1 for exactly the cycle after N, with digits stable and valid in that same cycle. Consumers sample on `status`.
- Cycle after CONFIRM: status returns to 0, digits to 4'hF, count to 0.
- Timeout: `timed_out` is high for the single cycle in which the fields read 4'hF.
- `busy` is registered and equals (state == COLLECT).
- Reset mid-entry or mid-CONFIRM aborts immediately; no status pulse is produced.

## Structure
- Shared package `lock_pkg`:
  - `pinPac_t` typedef, moved out of the consumer files.
  - `KEY_STAR`=4'hA, `KEY_HASH`=4'hB.
  - `DIGIT_INVALID`=4'hF.
  - Collector state enum.
- Sub-module `entry_timer`, parameterised by `TIMEOUT_CYCLES`:
  - Inputs: `clear`, `run`.
  - Output: `expired` pulse.
  - Instantiated once.
- The FSM, digit window and output registers stay in `pin_entry_collector`.

## Test plan
- Keys 1,2,3,4,`*` → one cycle of `pin_out` = {1,1,2,3,4}; the next cycle shows {0,F,F,F,F} with `digit_count`=0.
- Keys 9,8,7,6,5,`*` → status pulse with digits 8,7,6,5.
- Keys 3,7,`*` → status pulse with {3,7,F,F}; a connected `update_master` keeps its stored PIN.
- Keys 5,5,`#`,1,2,3,4,`*` → only one status pulse, carrying 1,2,3,4; `#` drops the count to 0 the cycle after.
- `TIMEOUT_CYCLES`=10, key 4, then idle for 10 cycles → `timed_out` pulses once and the fields read F.
- Variant of the previous case: a key arrives on the expiry cycle → no timeout, the digit is taken, and the timer restarts.
- Key 2, key 4'hC, `*` issued during the CONFIRM cycle, and `rst` asserted mid-entry → 4'hC is ignored, the extra `*` is dropped, and reset gives all-F with no pulse.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the PIN lock datapath.
// - pinPac_t: packet produced by pin_entry_collector and read by the PIN
//   consumers (master-PIN updater, PIN comparator). digit1 is the oldest digit.
// - Keypad codes for confirm/clear and the filler used for unfilled fields.
// - State type of the entry collector FSM.
package lock_pkg;

    localparam logic [3:0] KEY_STAR      = 4'hA;
    localparam logic [3:0] KEY_HASH      = 4'hB;
    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CONFIRM
    } collector_state_t;

endpackage

// File: rtl/entry_timer.sv
// Inactivity timer for the PIN entry collector.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - zero the count (takes priority over run)
//   run       - count this cycle
//   expired   - combinational pulse in the cycle the count reaches TIMEOUT_CYCLES
// TIMEOUT_CYCLES = 0 disables expiry. The counter saturates instead of wrapping.
module entry_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd125_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW =
        (TIMEOUT_CYCLES < 32'd2) ? 1 : $clog2({1'b0, TIMEOUT_CYCLES} + 33'd1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 32'd1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires on the run cycle that would bring the count up to TIMEOUT_CYCLES.
    assign expired = (TIMEOUT_CYCLES != 32'd0) && run && !clear && (cnt == LAST);

endmodule

// File: rtl/pin_entry_collector.sv
// Collects debounced keypad presses into a pinPac_t packet.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   key_valid    - one-cycle strobe per debounced key press
//   key_code     - 0-9 digit, A confirm, B clear, C-F ignored
//   pin_out      - {status, digit1..digit4}; status pulses one cycle on confirm
//   digit_count  - digits held (0-4)
//   busy         - high while collecting
//   timed_out    - one-cycle pulse when inactivity discards an entry
// Holds the last four digits typed; unfilled fields read DIGIT_INVALID.
module pin_entry_collector
    import lock_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd125_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output pinPac_t    pin_out,
    output logic [2:0] digit_count,
    output logic       busy,
    output logic       timed_out
);

    collector_state_t  state_q, state_n;
    logic [0:3][3:0]   digits_q, digits_n;   // index 0 is digit1
    logic [2:0]        count_q, count_n;
    logic              status_q, status_n;
    logic              busy_q;
    logic              timed_out_q, timed_out_n;
    logic              accepted;
    logic              expired;
    logic              is_digit;

    assign is_digit = (key_code <= 4'd9);

    entry_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (accepted || (state_q != ST_COLLECT)),
        .run     ((state_q == ST_COLLECT) && !key_valid),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            digits_q    <= {4{DIGIT_INVALID}};
            count_q     <= '0;
            status_q    <= 1'b0;
            busy_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            digits_q    <= digits_n;
            count_q     <= count_n;
            status_q    <= status_n;
            busy_q      <= (state_n == ST_COLLECT);
            timed_out_q <= timed_out_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        digits_n    = digits_q;
        count_n     = count_q;
        status_n    = 1'b0;
        timed_out_n = 1'b0;
        accepted    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_valid && is_digit) begin
                    digits_n = {key_code, DIGIT_INVALID, DIGIT_INVALID, DIGIT_INVALID};
                    count_n  = 3'd1;
                    state_n  = ST_COLLECT;
                    accepted = 1'b1;
                end else if (key_valid && (key_code == KEY_STAR)) begin
                    status_n = 1'b1;
                    state_n  = ST_CONFIRM;
                    accepted = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (key_valid) begin
                    if (is_digit) begin
                        accepted = 1'b1;
                        if (count_q != 3'd4) begin
                            digits_n[count_q[1:0]] = key_code;
                            count_n = count_q + 3'd1;
                        end else begin
                            digits_n = {digits_q[1], digits_q[2], digits_q[3], key_code};
                        end
                    end else if (key_code == KEY_STAR) begin
                        accepted = 1'b1;
                        status_n = 1'b1;
                        state_n  = ST_CONFIRM;
                    end else if (key_code == KEY_HASH) begin
                        accepted = 1'b1;
                        digits_n = {4{DIGIT_INVALID}};
                        count_n  = '0;
                        state_n  = ST_IDLE;
                    end
                end else if (expired) begin
                    digits_n    = {4{DIGIT_INVALID}};
                    count_n     = '0;
                    timed_out_n = 1'b1;
                    state_n     = ST_IDLE;
                end
            end
            ST_CONFIRM: begin
                digits_n = {4{DIGIT_INVALID}};
                count_n  = '0;
                state_n  = ST_IDLE;
            end
            default: begin
                digits_n = {4{DIGIT_INVALID}};
                count_n  = '0;
                state_n  = ST_IDLE;
            end
        endcase
    end

    assign pin_out.status = status_q;
    assign pin_out.digit1 = digits_q[0];
    assign pin_out.digit2 = digits_q[1];
    assign pin_out.digit3 = digits_q[2];
    assign pin_out.digit4 = digits_q[3];
    assign digit_count    = count_q;
    assign busy           = busy_q;
    assign timed_out      = timed_out_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Randomized bench for pin_entry_collector against a queue-based model of the
// keypad entry rules, preceded by the directed key sequences.
module tb_pin_entry_collector;
    import lock_pkg::*;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    pinPac_t    pin_out;
    logic [2:0] digit_count;
    logic       busy;
    logic       timed_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: last digits typed, plus entry/confirm flags and idle count.
    int q[$];
    bit m_entry, m_confirm, m_status, m_to;
    int m_idle;

    pin_entry_collector #(.TIMEOUT_CYCLES(32'd10)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .pin_out     (pin_out),
        .digit_count (digit_count),
        .busy        (busy),
        .timed_out   (timed_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] model_pin();
        logic [16:0] p;
        p[16] = m_status;
        for (int i = 0; i < 4; i++)
            p[15 - 4*i -: 4] = (i < q.size()) ? 4'(q[i]) : 4'hF;
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        m_entry = 0; m_confirm = 0; m_status = 0; m_to = 0; m_idle = 0;
    endtask

    task automatic model_edge(input logic kv, input logic [3:0] kc);
        m_to = 0;
        m_status = 0;
        if (m_confirm) begin
            m_confirm = 0;
            q.delete();
        end else if (m_entry) begin
            if (kv) begin
                if (kc <= 9) begin
                    q.push_back(int'(kc));
                    if (q.size() > 4) void'(q.pop_front());
                    m_idle = 0;
                end else if (kc == 4'hA) begin
                    m_confirm = 1; m_status = 1; m_entry = 0; m_idle = 0;
                end else if (kc == 4'hB) begin
                    q.delete(); m_entry = 0; m_idle = 0;
                end
            end else begin
                m_idle++;
                if (m_idle >= TO) begin
                    q.delete(); m_entry = 0; m_to = 1; m_idle = 0;
                end
            end
        end else if (kv) begin
            if (kc <= 9) begin
                q.delete(); q.push_back(int'(kc)); m_entry = 1; m_idle = 0;
            end else if (kc == 4'hA) begin
                m_confirm = 1; m_status = 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("pin_out", 32'(pin_out), 32'(model_pin()));
        check_eq("digit_count", 32'(digit_count), 32'(q.size()));
        check_eq("busy", 32'(busy), 32'(m_entry));
        check_eq("timed_out", 32'(timed_out), 32'(m_to));
    endtask

    task automatic step(input logic kv, input logic [3:0] kc);
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_edge(kv, kc);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        key_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_pin", 32'(pin_out), 32'h0FFFF);
        check_eq("rst_count", 32'(digit_count), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_timed_out", 32'(timed_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [3:0] kc;
        model_reset();
        do_reset();

        // 1,2,3,4,* then the cleared cycle
        step(1, 4'd1); step(1, 4'd2); step(1, 4'd3); step(1, 4'd4);
        step(1, KEY_STAR);
        check_eq("tp1_pulse", 32'(pin_out), 32'h11234);
        step(0, 4'h0);
        check_eq("tp1_after", 32'(pin_out), 32'h0FFFF);
        check_eq("tp1_count", 32'(digit_count), 32'd0);

        // 9,8,7,6,5,* keeps the last four
        step(1, 4'd9); step(1, 4'd8); step(1, 4'd7); step(1, 4'd6); step(1, 4'd5);
        step(1, KEY_STAR);
        check_eq("tp2_pulse", 32'(pin_out), 32'h18765);
        step(0, 4'h0);

        // 3,7,* short entry
        step(1, 4'd3); step(1, 4'd7); step(1, KEY_STAR);
        check_eq("tp3_pulse", 32'(pin_out), 32'h137FF);
        step(0, 4'h0);

        // 5,5,#,1,2,3,4,* : one pulse only
        pulses = 0;
        step(1, 4'd5); step(1, 4'd5); pulses += int'(pin_out.status);
        step(1, KEY_HASH);
        check_eq("tp4_hash_count", 32'(digit_count), 32'd0);
        step(1, 4'd1); step(1, 4'd2); step(1, 4'd3); step(1, 4'd4);
        step(1, KEY_STAR); pulses += int'(pin_out.status);
        check_eq("tp4_pulse", 32'(pin_out), 32'h11234);
        step(0, 4'h0); pulses += int'(pin_out.status);
        check_eq("tp4_pulses", 32'(pulses), 32'd1);

        // timeout after 10 idle cycles
        step(1, 4'd4);
        idle(TO - 1);
        check_eq("tp5_pre", 32'(timed_out), 32'd0);
        step(0, 4'h0);
        check_eq("tp5_to", 32'(timed_out), 32'd1);
        check_eq("tp5_pin", 32'(pin_out), 32'h0FFFF);
        step(0, 4'h0);
        check_eq("tp5_once", 32'(timed_out), 32'd0);

        // key on the expiry cycle wins, timer restarts
        step(1, 4'd4);
        idle(TO - 1);
        step(1, 4'd6);
        check_eq("tp6_no_to", 32'(timed_out), 32'd0);
        check_eq("tp6_pin", 32'(pin_out), 32'h046FF);
        idle(TO - 1);
        check_eq("tp6_busy", 32'(busy), 32'd1);
        step(0, 4'h0);
        check_eq("tp6_to", 32'(timed_out), 32'd1);

        // ignored code, * during CONFIRM, reset mid-entry
        step(1, 4'd2); step(1, 4'hC);
        check_eq("tp7_ign", 32'(digit_count), 32'd1);
        step(1, KEY_STAR); step(1, KEY_STAR);
        check_eq("tp7_drop", 32'(pin_out.status), 32'd0);
        step(1, 4'd8); step(1, 4'd1);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else if (r < 6) begin
                idle(int'($urandom_range(8, 12)));
            end else if (r < 50) begin
                int c;
                c = int'($urandom_range(0, 99));
                if (c < 68)      kc = 4'($urandom_range(0, 9));
                else if (c < 80) kc = KEY_STAR;
                else if (c < 88) kc = KEY_HASH;
                else             kc = 4'($urandom_range(12, 15));
                step(1'b1, kc);
            end else begin
                step(1'b0, 4'($urandom_range(0, 15)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
